// File: rtl/xpb_table_writer.sv
// xpb_table_writer: fills one XPB reduction table, entry k = (k * base) mod modulus.
// The table is walked by repeated modular addition, so only one adder and one
// conditional subtractor are needed. Each entry goes to the sink through a
// valid/ready handshake.
module xpb_table_writer #(
  parameter int WIDTH    = 1024,
  parameter int SEL_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    base,
  input  logic [WIDTH-1:0]    modulus,
  output logic                busy,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [SEL_BITS-1:0] wr_addr,
  output logic [WIDTH-1:0]    wr_data,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, EMIT, ADD, DONE} state_t;

  localparam logic [SEL_BITS-1:0] IDX_LAST = '1;
  localparam logic [SEL_BITS-1:0] IDX_ONE  = SEL_BITS'(1);

  state_t              state;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    base_r;
  logic [WIDTH-1:0]    mod_r;
  logic [SEL_BITS-1:0] idx;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    acc_next;

  // The accumulator and index are the presented entry, so they drive the write port directly.
  assign wr_addr = idx;
  assign wr_data = acc;

  // Next table entry: acc + base, with one subtraction because both operands are below the modulus.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, base_r};
    acc_next = sum[WIDTH-1:0];
    if (sum >= {1'b0, mod_r}) begin
      acc_next = sum[WIDTH-1:0] - mod_r;
    end
  end

  // Control FSM: validate and latch the request, emit each entry, step the accumulator, signal completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      acc      <= '0;
      base_r   <= '0;
      mod_r    <= '0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            if ((modulus == '0) || (base >= modulus)) begin
              err <= 1'b1;
            end else begin
              base_r   <= base;
              mod_r    <= modulus;
              acc      <= '0;
              idx      <= '0;
              busy     <= 1'b1;
              wr_valid <= 1'b1;
              state    <= EMIT;
            end
          end
        end

        EMIT: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            if (idx == IDX_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= ADD;
            end
          end
        end

        ADD: begin
          acc      <= acc_next;
          idx      <= idx + IDX_ONE;
          wr_valid <= 1'b1;
          state    <= EMIT;
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          wr_valid <= 1'b0;
          done     <= 1'b0;
          err      <= 1'b0;
        end
      endcase
    end
  end

endmodule
